// File: rtl/yol_olcer.sv
// rtl/yol_olcer.sv - two-segment road length meter (stony then asphalt) feeding the route selector
//
// Counts distance ticks over a stony segment followed by an asphalt segment,
// divides them by TIK_BOLME into unit lengths, saturates and holds the result.
//
// Ports:
//   clk                  rising-edge clock
//   rst                  synchronous active-high reset, highest priority
//   basla                start a new measurement (accepted in BOS / HAZIR only)
//   tik                  one distance tick (counted in OLC_* states only)
//   bitir                end of the current segment (OLC_* states only)
//   tasli_yol_uzunlugu   stony length, 1 bit, saturates at 1
//   asfalt_yol_uzunlugu  asphalt length, 3 bits, saturates at 7
//   gecerli              lengths valid (state HAZIR)
//   mesgul               measurement in progress (OLC_TASLI / OLC_ASFALT)

module yol_olcer #(
    parameter int TIK_BOLME = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       basla,
    input  logic       tik,
    input  logic       bitir,
    output logic       tasli_yol_uzunlugu,
    output logic [2:0] asfalt_yol_uzunlugu,
    output logic       gecerli,
    output logic       mesgul
);

    localparam int PW = $clog2(TIK_BOLME);
    localparam logic [PW-1:0] PRESC_LAST = PW'(TIK_BOLME - 1);

    typedef enum logic [1:0] {
        BOS        = 2'd0,
        OLC_TASLI  = 2'd1,
        OLC_ASFALT = 2'd2,
        HAZIR      = 2'd3
    } state_t;

    state_t        state_q, state_d;
    logic [PW-1:0] presc_q, presc_d;
    logic          tasli_cnt_q, tasli_cnt_d;
    logic [2:0]    asfalt_cnt_q, asfalt_cnt_d;
    logic          tasli_out_q, tasli_out_d;
    logic [2:0]    asfalt_out_q, asfalt_out_d;
    logic          gecerli_q, gecerli_d;
    logic          mesgul_q, mesgul_d;

    logic          olcum;
    logic          birim;

    // A unit is produced only on the tick that wraps the prescaler while measuring.
    assign olcum = (state_q == OLC_TASLI) || (state_q == OLC_ASFALT);
    assign birim = olcum && tik && (presc_q == PRESC_LAST);

    always_comb begin
        state_d      = state_q;
        presc_d      = presc_q;
        tasli_cnt_d  = tasli_cnt_q;
        asfalt_cnt_d = asfalt_cnt_q;
        tasli_out_d  = tasli_out_q;
        asfalt_out_d = asfalt_out_q;
        gecerli_d    = gecerli_q;
        mesgul_d     = mesgul_q;

        if (olcum && tik) begin
            presc_d = birim ? '0 : presc_q + PW'(1);
        end

        case (state_q)
            BOS, HAZIR: begin
                // Output registers keep the previous result during the new run.
                if (basla) begin
                    state_d      = OLC_TASLI;
                    presc_d      = '0;
                    tasli_cnt_d  = 1'b0;
                    asfalt_cnt_d = 3'd0;
                    gecerli_d    = 1'b0;
                    mesgul_d     = 1'b1;
                end
            end
            OLC_TASLI: begin
                if (birim) begin
                    tasli_cnt_d = 1'b1;
                end
                if (bitir) begin
                    // Partial stony units are dropped at the segment boundary.
                    state_d = OLC_ASFALT;
                    presc_d = '0;
                end
            end
            OLC_ASFALT: begin
                if (birim && (asfalt_cnt_q != 3'd7)) begin
                    asfalt_cnt_d = asfalt_cnt_q + 3'd1;
                end
                if (bitir) begin
                    // Load the next-state count so a coincident tick is included.
                    state_d      = HAZIR;
                    tasli_out_d  = tasli_cnt_q;
                    asfalt_out_d = asfalt_cnt_d;
                    gecerli_d    = 1'b1;
                    mesgul_d     = 1'b0;
                end
            end
            default: begin
                state_d = BOS;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= BOS;
            presc_q      <= '0;
            tasli_cnt_q  <= 1'b0;
            asfalt_cnt_q <= 3'd0;
            tasli_out_q  <= 1'b0;
            asfalt_out_q <= 3'd0;
            gecerli_q    <= 1'b0;
            mesgul_q     <= 1'b0;
        end else begin
            state_q      <= state_d;
            presc_q      <= presc_d;
            tasli_cnt_q  <= tasli_cnt_d;
            asfalt_cnt_q <= asfalt_cnt_d;
            tasli_out_q  <= tasli_out_d;
            asfalt_out_q <= asfalt_out_d;
            gecerli_q    <= gecerli_d;
            mesgul_q     <= mesgul_d;
        end
    end

    assign tasli_yol_uzunlugu  = tasli_out_q;
    assign asfalt_yol_uzunlugu = asfalt_out_q;
    assign gecerli             = gecerli_q;
    assign mesgul              = mesgul_q;

endmodule

// File: tb/tb_yol_olcer.sv
// tb/tb_yol_olcer.sv - directed self-checking bench for yol_olcer

module tb_yol_olcer;

    logic       clk;
    logic       rst;
    logic       basla;
    logic       tik;
    logic       bitir;
    logic       tasli_yol_uzunlugu;
    logic [2:0] asfalt_yol_uzunlugu;
    logic       gecerli;
    logic       mesgul;

    int checks;
    int errors;

    yol_olcer #(.TIK_BOLME(4)) dut (
        .clk                 (clk),
        .rst                 (rst),
        .basla               (basla),
        .tik                 (tik),
        .bitir               (bitir),
        .tasli_yol_uzunlugu  (tasli_yol_uzunlugu),
        .asfalt_yol_uzunlugu (asfalt_yol_uzunlugu),
        .gecerli             (gecerli),
        .mesgul              (mesgul)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // One clock with the given inputs; outputs sampled 1 time unit after the edge.
    task automatic cyc(input logic r, input logic b, input logic t, input logic e);
        rst = r; basla = b; tik = t; bitir = e;
        @(posedge clk);
        #1;
        rst = 1'b0; basla = 1'b0; tik = 1'b0; bitir = 1'b0;
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) cyc(1'b0, 1'b0, 1'b1, 1'b0);
    endtask

    task automatic outs(input string tag, input int t, input int a, input int g, input int m);
        chk({tag, "_tasli"},   int'(tasli_yol_uzunlugu),  t);
        chk({tag, "_asfalt"},  int'(asfalt_yol_uzunlugu), a);
        chk({tag, "_gecerli"}, int'(gecerli),             g);
        chk({tag, "_mesgul"},  int'(mesgul),              m);
    endtask

    initial begin
        checks = 0;
        errors = 0;
        rst = 1'b1; basla = 1'b0; tik = 1'b0; bitir = 1'b0;
        cyc(1'b1, 1'b0, 1'b0, 1'b0);
        cyc(1'b1, 1'b0, 1'b0, 1'b0);
        outs("reset", 0, 0, 0, 0);

        // tik and bitir in BOS are ignored
        ticks(6);
        cyc(1'b0, 1'b0, 1'b1, 1'b1);
        outs("bos_ignore", 0, 0, 0, 0);

        // nominal: 5 stony, 13 asphalt -> 1 / 3
        cyc(1'b0, 1'b1, 1'b0, 1'b0);
        outs("nom_start", 0, 0, 0, 1);
        ticks(5);
        cyc(1'b0, 1'b0, 1'b0, 1'b1);
        ticks(13);
        outs("nom_mid", 0, 0, 0, 1);
        cyc(1'b0, 1'b0, 1'b0, 1'b1);
        outs("nom_done", 1, 3, 1, 0);

        // tik and bitir in HAZIR are ignored, results held
        ticks(8);
        cyc(1'b0, 1'b0, 1'b1, 1'b1);
        outs("hazir_hold", 1, 3, 1, 0);

        // back-to-back: run to 1 / 2, then 0 stony + 20 asphalt -> 0 / 5
        cyc(1'b0, 1'b1, 1'b0, 1'b0);
        ticks(4);
        cyc(1'b0, 1'b0, 1'b0, 1'b1);
        ticks(8);
        cyc(1'b0, 1'b0, 1'b0, 1'b1);
        outs("b2b_run1", 1, 2, 1, 0);
        cyc(1'b0, 1'b1, 1'b0, 1'b0);
        outs("b2b_start", 1, 2, 0, 1);
        cyc(1'b0, 1'b0, 1'b0, 1'b1);
        ticks(20);
        outs("b2b_mid", 1, 2, 0, 1);
        cyc(1'b0, 1'b0, 1'b0, 1'b1);
        outs("b2b_run2", 0, 5, 1, 0);

        // saturation: 3 stony, 40 asphalt -> 0 / 7
        cyc(1'b0, 1'b1, 1'b0, 1'b0);
        ticks(3);
        cyc(1'b0, 1'b0, 1'b0, 1'b1);
        ticks(40);
        cyc(1'b0, 1'b0, 1'b0, 1'b1);
        outs("sat", 0, 7, 1, 0);

        // stony remainder does not carry: 3 stony + 1 asphalt -> 0 / 0
        cyc(1'b0, 1'b1, 1'b0, 1'b0);
        ticks(3);
        cyc(1'b0, 1'b0, 1'b0, 1'b1);
        ticks(1);
        cyc(1'b0, 1'b0, 1'b0, 1'b1);
        outs("nocarry", 0, 0, 1, 0);

        // 4th stony tick coincident with bitir -> tasli 1
        cyc(1'b0, 1'b1, 1'b0, 1'b0);
        ticks(3);
        cyc(1'b0, 1'b0, 1'b1, 1'b1);
        cyc(1'b0, 1'b0, 1'b0, 1'b1);
        outs("simul_tasli", 1, 0, 1, 0);

        // 4th asphalt tick coincident with bitir -> asfalt 1
        cyc(1'b0, 1'b1, 1'b0, 1'b0);
        cyc(1'b0, 1'b0, 1'b0, 1'b1);
        ticks(3);
        cyc(1'b0, 1'b0, 1'b1, 1'b1);
        outs("simul_asfalt", 0, 1, 1, 0);

        // basla during OLC_TASLI does not restart: 2 + 2 ticks still makes one unit
        cyc(1'b0, 1'b1, 1'b0, 1'b0);
        ticks(2);
        cyc(1'b0, 1'b1, 1'b0, 1'b0);
        outs("basla_ign", 0, 1, 0, 1);
        ticks(2);
        cyc(1'b0, 1'b0, 1'b0, 1'b1);
        cyc(1'b0, 1'b0, 1'b0, 1'b1);
        outs("basla_ign_done", 1, 0, 1, 0);

        // minimum measurement: basla, bitir, bitir
        cyc(1'b0, 1'b1, 1'b0, 1'b0);
        cyc(1'b0, 1'b0, 1'b0, 1'b1);
        cyc(1'b0, 1'b0, 1'b0, 1'b1);
        outs("minimum", 0, 0, 1, 0);

        // reset mid-OLC_ASFALT after 9 ticks, held 2 cycles
        cyc(1'b0, 1'b1, 1'b0, 1'b0);
        ticks(4);
        cyc(1'b0, 1'b0, 1'b0, 1'b1);
        ticks(9);
        cyc(1'b1, 1'b0, 1'b1, 1'b0);
        outs("rst_mid", 0, 0, 0, 0);
        cyc(1'b1, 1'b1, 1'b1, 1'b1);
        outs("rst_prio", 0, 0, 0, 0);
        ticks(12);
        cyc(1'b0, 1'b0, 1'b0, 1'b1);
        outs("rst_after", 0, 0, 0, 0);
        cyc(1'b0, 1'b1, 1'b0, 1'b0);
        ticks(4);
        cyc(1'b0, 1'b0, 1'b0, 1'b1);
        cyc(1'b0, 1'b0, 1'b0, 1'b1);
        outs("rst_rerun", 1, 0, 1, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/yol_olcer.md
# yol_olcer

Road-length measurement stage placed directly upstream of the route selector. It counts distance ticks over two consecutive road segments: first the stony road, then the asphalt road. Tick counts are scaled into unit lengths, saturated, and presented as `tasli_yol_uzunlugu` (1 bit) and `asfalt_yol_uzunlugu` (3 bits). Those two outputs feed the selector's inputs of the same name, and `gecerli` qualifies them.

## Interface

- `TIK_BOLME`, default 4: distance ticks per unit length. Legal range 2..16.

- `clk`  input  1  rising-edge clock.
- `rst`  input  1  synchronous, active-high reset.
- `basla`  input  1  single-cycle start of a new measurement.
- `tik`  input  1  single-cycle distance tick, at most one per cycle.
- `bitir`  input  1  single-cycle end-of-current-segment marker.
- `tasli_yol_uzunlugu`  output  1  registered stony-road length, saturating at 1.
- `asfalt_yol_uzunlugu`  output  3  registered asphalt-road length, saturating at 7.
- `gecerli`  output  1  lengths valid; high in state HAZIR.
- `mesgul`  output  1  measurement in progress; high in OLC_TASLI and OLC_ASFALT.

## Operation

- Reset values: state BOS; all outputs 0; prescaler 0; internal counters 0.
- States:
  - **BOS**: idle. `basla` → OLC_TASLI.
  - **OLC_TASLI**: counts stony ticks. `bitir` → OLC_ASFALT.
  - **OLC_ASFALT**: counts asphalt ticks. `bitir` → HAZIR.
  - **HAZIR**: results held. `basla` → OLC_TASLI.
- Entering OLC_TASLI (from BOS or HAZIR):
  - clear the prescaler and both internal length counters;
  - drop `gecerli`;
  - keep the output registers unchanged (they hold the last results).
- Prescaler:
  - width ceil(log2(TIK_BOLME)) bits;
  - increments on `tik` in OLC_* states;
  - when at TIK_BOLME-1 with `tik`, it wraps to 0 and emits one unit to the active counter.
- Active counter saturation:
  - stony counter: 1-bit, stays at 1 once set;
  - asphalt counter: 3-bit, stays at 7.
- Segment change: entering OLC_ASFALT clears the prescaler. Partial units from the stony segment are discarded.
- On OLC_ASFALT → HAZIR, load both internal counters into the output registers. The asphalt counter value loaded includes any unit produced by a `tik` in that same cycle.
- `tik` and `bitir` in the same cycle: the tick is counted into the current segment, then the transition happens.
- `tik` in BOS or HAZIR is ignored, as is `bitir` in BOS or HAZIR.
- `basla` in OLC_* states is ignored; it does not restart the measurement.
- `rst` mid-measurement: immediate return to reset values at the next edge, discarding the partial measurement and clearing the outputs.
- `rst` has priority over every other input.

## Timing

- All outputs are registered; there are no combinational input-to-output paths.
- `basla` sampled at edge N → `mesgul`=1 and `gecerli`=0 from edge N.
- `bitir` in OLC_ASFALT sampled at edge N → new lengths, `gecerli`=1 and `mesgul`=0 all from edge N, in the same cycle.
- `gecerli` stays high, with outputs stable, until the next accepted `basla` or `rst`.
- Minimum measurement: `basla`, `bitir`, `bitir` on consecutive cycles gives results in 3 cycles, both lengths 0.
- Throughput: one tick per cycle sustained; no back-pressure.

## Test plan

- **Reset.** Assert `rst` 2 cycles mid-OLC_ASFALT after 9 ticks → next edge all outputs 0, state BOS; subsequent `tik`s change nothing.
- **Nominal.** TIK_BOLME=4: `basla`; 5 ticks; `bitir`; 13 ticks; `bitir` → `tasli_yol_uzunlugu`=1, `asfalt_yol_uzunlugu`=3, `gecerli`=1 one edge after the second `bitir`.
- **Saturation and short stony segment.** 3 stony ticks then 40 asphalt ticks → tasli=0, asfalt=7. The prescaler remainder from stony does not carry: 3 stony + 1 asphalt tick gives asfalt=0.
- **Simultaneous tik and bitir.**
  - Stony segment: 3 ticks, then a 4th tick in the same cycle as `bitir` → tasli=1.
  - Asphalt segment: the same pattern (3 ticks, then a 4th with `bitir`) → asfalt=1.
- **Ignored inputs.** `basla` pulsed during OLC_TASLI → no restart, counts preserved. `bitir` and `tik` in BOS → stays BOS, outputs 0.
- **Back-to-back and downstream check.** HAZIR with tasli=1, asfalt=2; `basla` → `gecerli`=0 and outputs still 1/2 during measurement. A second run of 0 stony ticks and 20 asphalt ticks → tasli=0, asfalt=5. Downstream selector `tercih` is checked as 1 after run one and 0 after run two.
